// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : adc_pkg
//  Description : Shared constants for the AD7324 scan sequencer: channel
//                numbering, FSM state encoding and the control-word layout
//                with a helper that inserts a channel address into it.
//  Revision    : 1.0  initial release
// ============================================================================
package adc_pkg;

  // Channel numbering, also the AD7324 channel address
  localparam logic [1:0] CH_VOUT = 2'd0;
  localparam logic [1:0] CH_TEMP = 2'd1;
  localparam logic [1:0] CH_VIN  = 2'd2;
  localparam logic [1:0] CH_IOUT = 2'd3;

  // Sequencer state encoding
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ARM   = 3'd1;
  localparam logic [2:0] ST_XFER  = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_STORE = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ARM   = ST_ARM,
    S_XFER  = ST_XFER,
    S_WAIT  = ST_WAIT,
    S_STORE = ST_STORE
  } state_e;

  // Control-register write template and position of the channel address
  localparam logic [15:0] CTRL_BASE_DEF = 16'h8010;
  localparam int          ADDR_LSB      = 10;
  localparam int          ADDR_MSB      = 11;

  // Control word with the channel-address field replaced by ch
  function automatic logic [15:0] ctrl_word(input logic [15:0] base,
                                            input logic [1:0]  ch);
    logic [15:0] w;
    w                   = base;
    w[ADDR_MSB:ADDR_LSB] = ch;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : adc_rr_pick
//  Description : Combinational round-robin picker. Returns the next channel
//                after cur_ch whose mask bit is set, wrapping 3 -> 0. When
//                only cur_ch is enabled it returns cur_ch itself.
//  Ports       : cur_ch_i [1:0]  channel addressed most recently
//                mask_i   [3:0]  per-channel enable
//                nxt_o    [1:0]  next channel to address
//                any_o           at least one channel enabled
//  Revision    : 1.0  initial release
// ============================================================================
module adc_rr_pick
  import adc_pkg::*;
(
  input  logic [1:0] cur_ch_i,
  input  logic [3:0] mask_i,
  output logic [1:0] nxt_o,
  output logic       any_o
);

  assign any_o = |mask_i;

  // Walk candidates from farthest (cur+4 == cur) to nearest (cur+1) so the
  // nearest enabled channel is the last one written and therefore wins.
  always_comb begin
    logic [1:0] cand;
    cand  = cur_ch_i;
    nxt_o = cur_ch_i;
    for (int k = 4; k >= 1; k--) begin
      cand = cur_ch_i + 2'(k);
      if (mask_i[cand]) begin
        nxt_o = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_scan_sequencer
//  Description : Drives the AD7324 SPI core. One frame per sample period,
//                round-robin over enabled channels, channel-ID check on each
//                returned word, two's-complement -> offset-binary conversion
//                and per-channel result latching for compensator and LCD.
//  Ports       : clk, rst            clock, synchronous active-high reset
//                enable_i            run scanning / finish frame then idle
//                ch_mask_i  [3:0]    channel enables (0 Vout,1 Temp,2 Vin,3 Iout)
//                err_clr_i           clears chid_err_o and overrun_o
//                spi_start_o         one-cycle frame request
//                spi_tx_o   [15:0]   control word for the frame
//                spi_busy_i          SPI frame in progress
//                spi_done_i          frame complete, spi_rx_i valid
//                spi_rx_i   [15:0]   [14:13] channel ID, [12:0] code
//                vout_o..iout_o [M]  latest offset-binary result per channel
//                res_valid_o [3:0]   result-updated strobe per channel
//                chid_err_o          sticky channel-ID mismatch
//                overrun_o           sticky period expired mid-frame
//  Revision    : 1.0  initial release
// ============================================================================
module adc_scan_sequencer
  import adc_pkg::*;
#(
  parameter int          M             = 12,
  parameter int          PERIOD_CYCLES = 1000,
  parameter logic [15:0] CTRL_BASE     = CTRL_BASE_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         enable_i,
  input  logic [3:0]   ch_mask_i,
  input  logic         err_clr_i,
  output logic         spi_start_o,
  output logic [15:0]  spi_tx_o,
  input  logic         spi_busy_i,
  input  logic         spi_done_i,
  input  logic [15:0]  spi_rx_i,
  output logic [M-1:0] vout_o,
  output logic [M-1:0] temp_o,
  output logic [M-1:0] vin_o,
  output logic [M-1:0] iout_o,
  output logic [3:0]   res_valid_o,
  output logic         chid_err_o,
  output logic         overrun_o
);

  localparam int CW = (PERIOD_CYCLES > 2) ? $clog2(PERIOD_CYCLES) : 1;

  state_e              state_q,    state_d;
  logic [CW-1:0]       cnt_q,      cnt_d;
  logic                prime_q,    prime_d;
  logic [1:0]          cur_ch_q,   cur_ch_d;
  logic [1:0]          exp_ch_q,   exp_ch_d;
  logic                start_q,    start_d;
  logic [15:0]         tx_q,       tx_d;
  logic [3:0][M-1:0]   res_q,      res_d;
  logic [3:0]          valid_q,    valid_d;
  logic                chid_err_q, chid_err_d;
  logic                overrun_q,  overrun_d;

  logic [1:0]  nxt_ch;
  logic        any_ch;
  logic        run_ok;
  logic [12:0] pos;
  logic        id_ok;
  logic        unused_bits;

  adc_rr_pick u_pick (
    .cur_ch_i (cur_ch_q),
    .mask_i   (ch_mask_i),
    .nxt_o    (nxt_ch),
    .any_o    (any_ch)
  );

  assign run_ok = enable_i && any_ch;
  // Flipping the sign bit turns the two's-complement code into offset binary
  assign pos    = spi_rx_i[12:0] ^ 13'h1000;
  assign id_ok  = (spi_rx_i[14:13] == exp_ch_q);
  // Bit 15 of the returned word and the truncated LSBs carry no information
  assign unused_bits = ^{spi_rx_i[15], pos};

  always_comb begin
    state_d    = state_q;
    cnt_d      = (cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
    prime_d    = prime_q;
    cur_ch_d   = cur_ch_q;
    exp_ch_d   = exp_ch_q;
    start_d    = 1'b0;
    tx_d       = tx_q;
    res_d      = res_q;
    valid_d    = '0;
    chid_err_d = chid_err_q;
    overrun_d  = overrun_q;

    // Clear first so a same-cycle error below overrides it
    if (err_clr_i) begin
      chid_err_d = 1'b0;
      overrun_d  = 1'b0;
    end

    if ((state_q == S_XFER || state_q == S_WAIT) && cnt_q == '0) begin
      overrun_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (run_ok) begin
          state_d = S_ARM;
          prime_d = 1'b1;
          cnt_d   = '0;
        end
      end

      S_ARM: begin
        if (!run_ok) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0 && !spi_busy_i) begin
          start_d  = 1'b1;
          tx_d     = ctrl_word(CTRL_BASE, nxt_ch);
          exp_ch_d = cur_ch_q;
          cur_ch_d = nxt_ch;
          cnt_d    = CW'(PERIOD_CYCLES - 1);
          state_d  = S_XFER;
        end
      end

      // A done arriving while still in XFER is handled exactly as in WAIT.
      // Results are registered on the done edge so they appear one clock
      // later; STORE is the cycle in which the strobe is visible.
      S_XFER, S_WAIT: begin
        if (spi_done_i) begin
          state_d = S_STORE;
          if (prime_q) begin
            prime_d = 1'b0;
          end else if (!id_ok) begin
            chid_err_d = 1'b1;
          end else begin
            res_d[exp_ch_q]   = pos[12 -: M];
            valid_d[exp_ch_q] = 1'b1;
          end
        end else if (spi_busy_i) begin
          state_d = S_WAIT;
        end
      end

      S_STORE: begin
        state_d = run_ok ? S_ARM : S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      prime_q    <= 1'b1;
      cur_ch_q   <= CH_IOUT;
      exp_ch_q   <= CH_VOUT;
      start_q    <= 1'b0;
      tx_q       <= '0;
      res_q      <= '0;
      valid_q    <= '0;
      chid_err_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      prime_q    <= prime_d;
      cur_ch_q   <= cur_ch_d;
      exp_ch_q   <= exp_ch_d;
      start_q    <= start_d;
      tx_q       <= tx_d;
      res_q      <= res_d;
      valid_q    <= valid_d;
      chid_err_q <= chid_err_d;
      overrun_q  <= overrun_d;
    end
  end

  assign spi_start_o = start_q;
  assign spi_tx_o    = tx_q;
  assign vout_o      = res_q[CH_VOUT];
  assign temp_o      = res_q[CH_TEMP];
  assign vin_o       = res_q[CH_VIN];
  assign iout_o      = res_q[CH_IOUT];
  assign res_valid_o = valid_q;
  assign chid_err_o  = chid_err_q;
  assign overrun_o   = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_adc_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_adc_scan_sequencer
//  Description : Self-checking bench for adc_scan_sequencer with an AD7324
//                SPI responder that echoes the previously addressed channel
//                and a frame-level reference model of the sequencer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_adc_scan_sequencer;

  localparam int M   = 12;
  localparam int P   = 40;
  localparam int TMO = 400;

  logic         clk = 1'b0;
  logic         rst;
  logic         enable;
  logic [3:0]   ch_mask;
  logic         err_clr;
  logic         spi_start;
  logic [15:0]  spi_tx;
  logic         spi_busy;
  logic         spi_done;
  logic [15:0]  spi_rx;
  logic [M-1:0] vout, temp, vin, iout;
  logic [3:0]   res_valid;
  logic         chid_err;
  logic         overrun;

  adc_scan_sequencer #(.M(M), .PERIOD_CYCLES(P), .CTRL_BASE(16'h8010)) dut (
    .clk         (clk),
    .rst         (rst),
    .enable_i    (enable),
    .ch_mask_i   (ch_mask),
    .err_clr_i   (err_clr),
    .spi_start_o (spi_start),
    .spi_tx_o    (spi_tx),
    .spi_busy_i  (spi_busy),
    .spi_done_i  (spi_done),
    .spi_rx_i    (spi_rx),
    .vout_o      (vout),
    .temp_o      (temp),
    .vin_o       (vin),
    .iout_o      (iout),
    .res_valid_o (res_valid),
    .chid_err_o  (chid_err),
    .overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // Reference model state
  logic [M-1:0] m_res [4];
  bit           m_prime;
  logic [1:0]   m_cur;
  logic [1:0]   m_prev;
  logic [1:0]   m_last_ch;
  bit           m_err;
  bit           m_ovr;
  int           last_start;
  int           this_start;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] rr_next(input logic [1:0] cur, input logic [3:0] mask);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (int'(cur) + k) % 4;
      if (mask[c]) return 2'(c);
    end
    return cur;
  endfunction

  // Offset binary = signed value + 4096, keep the top M of 13 bits
  function automatic logic [M-1:0] to_result(input logic [12:0] code);
    int sv;
    sv = code[12] ? int'(code) - 8192 : int'(code);
    return M'((sv + 4096) >> (13 - M));
  endfunction

  function automatic logic [M-1:0] dut_res(input logic [1:0] ch);
    case (ch)
      2'd0:    return vout;
      2'd1:    return temp;
      2'd2:    return vin;
      default: return iout;
    endcase
  endfunction

  task automatic check_state(input string tag, input logic [3:0] ev);
    chk({tag, ":res_valid"}, res_valid, ev);
    chk({tag, ":vout"}, vout, m_res[0]);
    chk({tag, ":temp"}, temp, m_res[1]);
    chk({tag, ":vin"},  vin,  m_res[2]);
    chk({tag, ":iout"}, iout, m_res[3]);
    chk({tag, ":chid_err"}, chid_err, m_err);
    chk({tag, ":overrun"},  overrun,  m_ovr);
  endtask

  task automatic wait_start(output bit ok);
    int n;
    n = 0;
    while (spi_start !== 1'b1 && n < TMO) begin
      tick();
      n++;
    end
    ok = (spi_start === 1'b1);
    chk("start_seen", ok, 1'b1);
  endtask

  // One complete frame: request check, busy for flen clocks, done with the
  // echoed (or corrupted) channel ID, then result/flag check.
  task automatic frame(input int flen, input logic [12:0] code, input bit bad, input bit drop_en);
    bit         ok;
    logic [1:0] addr;
    logic [1:0] rid;
    logic [3:0] ev;
    wait_start(ok);
    if (!ok) return;
    this_start = cyc;
    addr = rr_next(m_cur, ch_mask);
    chk("spi_tx", spi_tx, 16'h8010 | (16'(addr) << 10));
    m_cur = addr;
    if (drop_en) enable = 1'b0;
    tick();
    chk("start_one_cycle", spi_start, 1'b0);
    spi_busy = 1'b1;
    repeat (flen - 1) tick();
    rid      = bad ? m_prev + 2'd1 : m_prev;
    spi_rx   = {1'b0, rid, code};
    spi_done = 1'b1;
    spi_busy = 1'b0;
    tick();
    spi_done = 1'b0;
    spi_rx   = 16'($urandom);
    ev = '0;
    if (m_prime) begin
      m_prime = 1'b0;
    end else if (bad) begin
      m_err = 1'b1;
    end else begin
      m_res[m_prev] = to_result(code);
      ev[m_prev]    = 1'b1;
      m_last_ch     = m_prev;
    end
    if (flen + 1 >= P) m_ovr = 1'b1;
    check_state("frame", ev);
    m_prev = addr;
    tick();
    chk("strobe_clear", res_valid, 4'h0);
  endtask

  task automatic pulse_err_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    m_err = 1'b0;
    m_ovr = 1'b0;
    chk("err_clr:chid_err", chid_err, 1'b0);
    chk("err_clr:overrun",  overrun,  1'b0);
  endtask

  task automatic model_reset();
    m_prime = 1'b1;
    m_cur   = 2'd3;
    m_prev  = 2'd0;
    m_last_ch = 2'd0;
    m_err   = 1'b0;
    m_ovr   = 1'b0;
    for (int i = 0; i < 4; i++) m_res[i] = '0;
  endtask

  initial begin
    logic [12:0] dcode [4];
    logic [M-1:0] dres [4];
    bit ok;
    int seen;

    rst = 1'b1; enable = 1'b0; ch_mask = 4'hF; err_clr = 1'b0;
    spi_busy = 1'b0; spi_done = 1'b0; spi_rx = '0;
    last_start = 0; this_start = 0;
    model_reset();
    repeat (3) tick();
    chk("reset:spi_start", spi_start, 1'b0);
    chk("reset:spi_tx", spi_tx, 16'h0000);
    check_state("reset", 4'h0);
    rst = 1'b0;
    tick();

    // Full mask, addresses 0,1,2,3,0..; first word discarded; exact period
    enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      frame(20, 13'($urandom), 1'b0, 1'b0);
      if (i > 0) chk("period_spacing", this_start - last_start, P);
      last_start = this_start;
    end

    // Conversion corner codes
    dcode[0] = 13'h1FFF; dres[0] = 12'h7FF;
    dcode[1] = 13'h0000; dres[1] = 12'h800;
    dcode[2] = 13'h0FFF; dres[2] = 12'hFFF;
    dcode[3] = 13'h1000; dres[3] = 12'h000;
    for (int i = 0; i < 4; i++) begin
      frame($urandom_range(10, 30), dcode[i], 1'b0, 1'b0);
      chk("conv_corner", dut_res(m_last_ch), dres[i]);
    end

    // Channel-ID mismatch when Temp is expected
    for (int i = 0; i < 4 && m_prev != 2'd1; i++) frame(20, 13'($urandom), 1'b0, 1'b0);
    frame(20, 13'($urandom), 1'b1, 1'b0);
    chk("chid_err_set", chid_err, 1'b1);
    pulse_err_clr();

    // Sparse mask, then switch to Iout only
    ch_mask = 4'b0101;
    for (int i = 0; i < 4; i++) frame($urandom_range(10, 30), 13'($urandom), 1'b0, 1'b0);
    ch_mask = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      frame($urandom_range(10, 30), 13'($urandom), 1'b0, 1'b0);
      chk("single_ch_addr", m_cur, 2'd3);
    end

    // Random mask / code / ID corruption
    for (int i = 0; i < 8; i++) begin
      ch_mask = 4'($urandom_range(1, 15));
      frame($urandom_range(10, 30), 13'($urandom), ($urandom_range(0, 7) == 0), 1'b0);
    end
    pulse_err_clr();

    // Enable drop mid-frame: frame completes and stores, then idles
    ch_mask = 4'hF;
    frame(20, 13'($urandom), 1'b0, 1'b1);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (spi_start === 1'b1) seen++;
    end
    chk("idle_no_start", seen, 0);
    enable  = 1'b1;
    m_prime = 1'b1;
    frame(20, 13'($urandom), 1'b0, 1'b0);
    frame(20, 13'($urandom), 1'b0, 1'b0);

    // Frames longer than the period: overrun and back-to-back starts
    last_start = this_start;
    frame(60, 13'($urandom), 1'b0, 1'b0);
    last_start = this_start;
    frame(60, 13'($urandom), 1'b0, 1'b0);
    chk("back_to_back", (this_start - last_start) <= 64, 1'b1);
    chk("overrun_set", overrun, 1'b1);
    pulse_err_clr();

    // Reset while waiting for the frame to finish
    wait_start(ok);
    if (ok) begin
      tick();
      spi_busy = 1'b1;
      repeat (5) tick();
    end
    rst = 1'b1;
    enable = 1'b0;
    tick();
    spi_busy = 1'b0;
    model_reset();
    chk("rst_mid:spi_start", spi_start, 1'b0);
    chk("rst_mid:spi_tx", spi_tx, 16'h0000);
    check_state("rst_mid", 4'h0);
    rst = 1'b0;
    tick();
    spi_rx   = {1'b0, 2'd0, 13'h0AAA};
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    chk("late_done:spi_start", spi_start, 1'b0);
    check_state("late_done", 4'h0);
    enable = 1'b1;
    frame(20, 13'($urandom), 1'b0, 1'b0);
    frame(20, 13'($urandom), 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
